// File: rtl/taxi_eth_tx_arb.sv
// taxi_eth_tx_arb: frame-granular round-robin arbiter in front of a MAC TX stream.
// Each granted frame carries its source index on m_axis_tid. Frames longer than
// MAX_BEATS are cut short: the cut beat is marked bad and the rest of the frame is dropped.
// Completions coming back from the MAC are steered to their source by tid.
module taxi_eth_tx_arb #(
    parameter int unsigned PORTS     = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned KEEP_W    = DATA_W / 8,
    parameter int unsigned ID_W      = 8,
    parameter int unsigned CPL_W     = 96,
    parameter int unsigned MAX_BEATS = 2048
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic [PORTS*DATA_W-1:0]   s_axis_tdata,
    input  logic [PORTS*KEEP_W-1:0]   s_axis_tkeep,
    input  logic [PORTS-1:0]          s_axis_tvalid,
    output logic [PORTS-1:0]          s_axis_tready,
    input  logic [PORTS-1:0]          s_axis_tlast,
    input  logic [PORTS-1:0]          s_axis_tuser,

    output logic [DATA_W-1:0]         m_axis_tdata,
    output logic [KEEP_W-1:0]         m_axis_tkeep,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
    output logic                      m_axis_tuser,
    output logic [ID_W-1:0]           m_axis_tid,

    input  logic [CPL_W-1:0]          s_cpl_tdata,
    input  logic [ID_W-1:0]           s_cpl_tid,
    input  logic                      s_cpl_tvalid,
    output logic                      s_cpl_tready,
    output logic [CPL_W-1:0]          m_cpl_tdata,
    output logic [PORTS-1:0]          m_cpl_tvalid,
    input  logic [PORTS-1:0]          m_cpl_tready,

    output logic                      busy,
    output logic [$clog2(PORTS)-1:0]  grant_idx,
    output logic [15:0]               trunc_count
);

    localparam int unsigned GW = $clog2(PORTS);
    localparam int unsigned CW = $clog2(MAX_BEATS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              r_state;
    logic [GW-1:0]       r_grant;
    logic [GW-1:0]       r_ptr;
    logic [CW-1:0]       r_beat_cnt;
    logic [15:0]         r_trunc_count;

    logic                w_any;
    logic [GW-1:0]       w_next;
    logic [DATA_W-1:0]   w_src_data;
    logic [KEEP_W-1:0]   w_src_keep;
    logic                w_src_valid;
    logic                w_src_last;
    logic                w_src_user;
    logic                w_beat;
    logic                w_trunc;

    // Round-robin search: first requester at or after r_ptr+1, wrapping at PORTS
    always_comb begin
        int unsigned v_base;
        int unsigned v_idx;
        logic [GW-1:0] v_cand;
        w_any  = 1'b0;
        w_next = '0;
        v_base = 32'(r_ptr);
        v_idx  = 0;
        v_cand = '0;
        for (int unsigned i = 1; i <= PORTS; i++) begin
            v_idx  = (v_base + i) % PORTS;
            v_cand = GW'(v_idx);
            if (!w_any && s_axis_tvalid[v_cand]) begin
                w_any  = 1'b1;
                w_next = v_cand;
            end
        end
    end

    // Select the granted source; non-granted ports never reach the output
    always_comb begin
        w_src_data  = '0;
        w_src_keep  = '0;
        w_src_valid = 1'b0;
        w_src_last  = 1'b0;
        w_src_user  = 1'b0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            if (r_grant == GW'(i)) begin
                w_src_data  = s_axis_tdata[i*DATA_W +: DATA_W];
                w_src_keep  = s_axis_tkeep[i*KEEP_W +: KEEP_W];
                w_src_valid = s_axis_tvalid[i];
                w_src_last  = s_axis_tlast[i];
                w_src_user  = s_axis_tuser[i];
            end
        end
    end

    assign w_beat  = (r_state == XFER) && w_src_valid && m_axis_tready;
    assign w_trunc = (r_state == XFER) && (r_beat_cnt == CW'(MAX_BEATS - 1)) && !w_src_last;

    // Arbitration state machine: grant, frame transfer, truncation drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_grant       <= '0;
            r_ptr         <= GW'(PORTS - 1);
            r_beat_cnt    <= '0;
            r_trunc_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant    <= w_next;
                        r_ptr      <= w_next;
                        r_beat_cnt <= '0;
                        r_state    <= XFER;
                    end
                end
                XFER: begin
                    if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + CW'(1);
                        if (w_trunc) begin
                            if (r_trunc_count != '1) begin
                                r_trunc_count <= r_trunc_count + 16'd1;
                            end
                            r_state <= DRAIN;
                        end else if (w_src_last) begin
                            r_state <= IDLE;
                        end
                    end
                end
                DRAIN: begin
                    if (w_src_valid && w_src_last) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Source ready: follow the MAC while transferring, swallow beats while draining
    always_comb begin
        s_axis_tready = '0;
        if (r_state == XFER) begin
            s_axis_tready[r_grant] = m_axis_tready;
        end else if (r_state == DRAIN) begin
            s_axis_tready[r_grant] = 1'b1;
        end
    end

    // Output stream; truncation forces end-of-frame and the bad-frame flag
    always_comb begin
        m_axis_tdata  = w_src_data;
        m_axis_tkeep  = w_src_keep;
        m_axis_tvalid = (r_state == XFER) && w_src_valid;
        m_axis_tlast  = w_src_last | w_trunc;
        m_axis_tuser  = w_src_user | w_trunc;
        m_axis_tid    = '0;
        m_axis_tid[GW-1:0] = r_grant;
    end

    // Completion steering by tid; out-of-range ids are accepted and dropped
    always_comb begin
        m_cpl_tdata  = s_cpl_tdata;
        m_cpl_tvalid = '0;
        s_cpl_tready = 1'b1;
        for (int unsigned i = 0; i < PORTS; i++) begin
            if (s_cpl_tid == ID_W'(i)) begin
                m_cpl_tvalid[i] = s_cpl_tvalid;
                s_cpl_tready    = m_cpl_tready[i];
            end
        end
    end

    assign busy        = (r_state != IDLE);
    assign grant_idx   = r_grant;
    assign trunc_count = r_trunc_count;

endmodule

// File: tb/tb_taxi_eth_tx_arb.sv
// Bench for taxi_eth_tx_arb: per-port source FIFOs feed the DUT, expected output
// beats are queued as frames are scheduled and compared as the DUT emits them.
module tb_taxi_eth_tx_arb;

    localparam int unsigned PORTS = 4;
    localparam int unsigned MAXB  = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [PORTS*8-1:0] s_axis_tdata = '0;
    logic [PORTS-1:0]   s_axis_tkeep = '1;
    logic [PORTS-1:0]   s_axis_tvalid = '0;
    logic [PORTS-1:0]   s_axis_tready;
    logic [PORTS-1:0]   s_axis_tlast = '0;
    logic [PORTS-1:0]   s_axis_tuser = '0;
    logic [7:0]         m_axis_tdata;
    logic [0:0]         m_axis_tkeep;
    logic               m_axis_tvalid;
    logic               m_axis_tready = 1'b1;
    logic               m_axis_tlast;
    logic               m_axis_tuser;
    logic [7:0]         m_axis_tid;
    logic [95:0]        s_cpl_tdata = '0;
    logic [7:0]         s_cpl_tid = '0;
    logic               s_cpl_tvalid = 1'b0;
    logic               s_cpl_tready;
    logic [95:0]        m_cpl_tdata;
    logic [PORTS-1:0]   m_cpl_tvalid;
    logic [PORTS-1:0]   m_cpl_tready = '0;
    logic               busy;
    logic [1:0]         grant_idx;
    logic [15:0]        trunc_count;

    taxi_eth_tx_arb #(
        .PORTS(PORTS), .DATA_W(8), .KEEP_W(1), .ID_W(8), .CPL_W(96), .MAX_BEATS(MAXB)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .m_axis_tid(m_axis_tid),
        .s_cpl_tdata(s_cpl_tdata), .s_cpl_tid(s_cpl_tid),
        .s_cpl_tvalid(s_cpl_tvalid), .s_cpl_tready(s_cpl_tready),
        .m_cpl_tdata(m_cpl_tdata), .m_cpl_tvalid(m_cpl_tvalid), .m_cpl_tready(m_cpl_tready),
        .busy(busy), .grant_idx(grant_idx), .trunc_count(trunc_count)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [31:0] sb[$];
    int unsigned sb_idx = 0;
    int          extra = 0;
    logic        gap_chk = 1'b0;
    int          gap_last = -1;
    logic        tgl_en = 1'b0;
    logic [PORTS-1:0] hs = '0;
    logic [9:0]  src_mem [PORTS][32];
    int unsigned src_rd [PORTS];
    int unsigned src_wr [PORTS];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: capture source handshakes and check output beats away from the active edge
    always @(negedge clk) begin
        hs = s_axis_tvalid & s_axis_tready;
        if (rst_n && m_axis_tvalid && m_axis_tready) begin
            if (sb_idx < sb.size()) begin
                check_eq("beat", 32'({m_axis_tid, m_axis_tuser, m_axis_tlast, m_axis_tdata}), sb[sb_idx]);
                sb_idx++;
            end else begin
                extra++;
            end
            if (gap_chk && gap_last >= 0) check_eq("gap", 32'(cyc - gap_last), 32'd2);
            gap_last = gap_chk ? cyc : -1;
        end
        if (!gap_chk) gap_last = -1;
    end

    // Source driver: present the head of each port FIFO; flush while in reset
    always @(posedge clk) begin
        #1;
        for (int p = 0; p < PORTS; p++) begin
            logic [9:0] b;
            if (!rst_n) src_rd[p] = src_wr[p];
            else if (hs[p]) src_rd[p]++;
            b = src_mem[p][src_rd[p] % 32];
            s_axis_tvalid[p]       = rst_n && (src_rd[p] != src_wr[p]);
            s_axis_tdata[p*8 +: 8] = b[7:0];
            s_axis_tuser[p]        = b[8];
            s_axis_tlast[p]        = b[9];
        end
        m_axis_tready = tgl_en ? ~m_axis_tready : 1'b1;
    end

    // Queue a frame on port p and push the beats the MAC side should see
    task automatic send_frame(input int p, input int n, input logic [7:0] base, input logic bad);
        for (int k = 0; k < n; k++) begin
            logic last_k, user_k, tr;
            logic [7:0] d;
            d      = base + 8'(k);
            last_k = (k == n - 1);
            user_k = bad && last_k;
            src_mem[p][src_wr[p] % 32] = {last_k, user_k, d};
            src_wr[p]++;
            if (k < int'(MAXB)) begin
                tr = (k == int'(MAXB) - 1) && (n > int'(MAXB));
                sb.push_back(32'({8'(p), user_k | tr, last_k | tr, d}));
            end
        end
    endtask

    task automatic wait_drain(input string tag);
        for (int c = 0; c < 300; c++) begin
            if (sb_idx == sb.size()) break;
            @(negedge clk); #1;
        end
        check_eq(tag, sb_idx, 32'(sb.size()));
        check_eq({tag, "_extra"}, 32'(extra), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        #1;
    endtask

    initial begin
        for (int p = 0; p < PORTS; p++) begin
            src_rd[p] = 0;
            src_wr[p] = 0;
        end

        // Reset state
        #2;
        check_eq("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check_eq("rst_tready", 32'(s_axis_tready), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_grant", 32'(grant_idx), 32'd0);
        check_eq("rst_trunc", 32'(trunc_count), 32'd0);
        do_reset();

        // 1: single 3-beat frame from port 2, busy falls one cycle after tlast
        send_frame(2, 3, 8'h20, 1'b0);
        wait_drain("t1_drain");
        check_eq("t1_busy_last", 32'(busy), 32'd1);
        @(negedge clk); #1;
        check_eq("t1_busy_after", 32'(busy), 32'd0);
        check_eq("t1_grant", 32'(grant_idx), 32'd2);

        // 2: all ports, 1-beat frames -> round-robin from port 0, one bubble per frame
        do_reset();
        gap_chk = 1'b1;
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < PORTS; p++)
                send_frame(p, 1, 8'(8'h40 + r*16 + p), 1'b0);
        wait_drain("t2_drain");
        gap_chk = 1'b0;

        // 3: exact-length frame on port 0 passes, 6-beat frame on port 1 is truncated
        do_reset();
        send_frame(0, 4, 8'h60, 1'b0);
        send_frame(1, 6, 8'h70, 1'b0);
        wait_drain("t3_drain");
        for (int c = 0; c < 50; c++) begin
            if (src_rd[1] == src_wr[1] && !busy) break;
            @(negedge clk); #1;
        end
        check_eq("t3_src_consumed", 32'(src_rd[1] == src_wr[1]), 32'd1);
        check_eq("t3_busy", 32'(busy), 32'd0);
        check_eq("t3_extra", 32'(extra), 32'd0);
        check_eq("t3_trunc_count", 32'(trunc_count), 32'd1);

        // 4: MAC ready toggling during a 5-beat frame; port 2 must stay stalled
        do_reset();
        tgl_en = 1'b1;
        send_frame(1, 5, 8'h80, 1'b0);
        send_frame(2, 2, 8'h90, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        check_eq("t4_grant", 32'(grant_idx), 32'd1);
        check_eq("t4_p2_valid", 32'(s_axis_tvalid[2]), 32'd1);
        check_eq("t4_p2_stalled", 32'(s_axis_tready[2]), 32'd0);
        wait_drain("t4_drain");
        tgl_en = 1'b0;

        // 5: completion steering
        s_cpl_tdata  = 96'hA5A5_0102_0304_0506_0708_C3C3;
        s_cpl_tid    = 8'd3;
        s_cpl_tvalid = 1'b1;
        m_cpl_tready = 4'b0000;
        #1;
        check_eq("t5_vld3", 32'(m_cpl_tvalid), 32'h8);
        check_eq("t5_rdy3_wait", 32'(s_cpl_tready), 32'd0);
        check_eq("t5_data_lo", m_cpl_tdata[31:0], 32'h0708_C3C3);
        check_eq("t5_data_hi", m_cpl_tdata[95:64], 32'hA5A5_0102);
        m_cpl_tready = 4'b0111;
        #1;
        check_eq("t5_rdy3_other", 32'(s_cpl_tready), 32'd0);
        m_cpl_tready = 4'b1000;
        #1;
        check_eq("t5_rdy3_go", 32'(s_cpl_tready), 32'd1);
        s_cpl_tid    = 8'd9;
        m_cpl_tready = 4'b0000;
        #1;
        check_eq("t5_vld9", 32'(m_cpl_tvalid), 32'h0);
        check_eq("t5_rdy9", 32'(s_cpl_tready), 32'd1);
        s_cpl_tid = 8'd0;
        #1;
        check_eq("t5_vld0", 32'(m_cpl_tvalid), 32'h1);
        s_cpl_tvalid = 1'b0;
        #1;
        check_eq("t5_vld0_off", 32'(m_cpl_tvalid), 32'h0);

        // 6: reset during beat 2 of a frame, then port 0 wins first
        do_reset();
        send_frame(2, 2, 8'hB0, 1'b0);
        src_mem[2][(src_wr[2] - 1) % 32][9] = 1'b0;
        src_mem[2][src_wr[2] % 32] = {1'b1, 1'b0, 8'hB2};
        src_wr[2]++;
        sb[sb.size() - 1] = 32'({8'd2, 1'b0, 1'b0, 8'hB1});
        for (int c = 0; c < 50; c++) begin
            if (sb_idx == sb.size()) break;
            @(negedge clk); #1;
        end
        check_eq("t6_two_beats", sb_idx, 32'(sb.size()));
        check_eq("t6_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("t6_tvalid", 32'(m_axis_tvalid), 32'd0);
        check_eq("t6_tready", 32'(s_axis_tready), 32'd0);
        check_eq("t6_busy", 32'(busy), 32'd0);
        check_eq("t6_grant", 32'(grant_idx), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        #1;
        send_frame(0, 1, 8'hC0, 1'b0);
        send_frame(3, 1, 8'hC3, 1'b0);
        wait_drain("t6_drain");

        repeat (3) @(negedge clk);
        check_eq("final_extra", 32'(extra), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "time limit");
    end

endmodule
